// File: rtl/bpu_2bit_dyn.sv
// Dynamic branch predictor: direct-mapped 2-bit counter table + BTB looked up at IF,
// branch resolution, redirect and table training driven from EX.
module bpu_2bit_dyn #(
  parameter int IDX_W = 6,
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_if_pc,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_target,
  input  logic        i_ex_valid,
  input  logic        i_ex_is_br,
  input  logic        i_ex_is_jmp,
  input  logic [31:0] i_ex_pc,
  input  logic [2:0]  i_ex_funct3,
  input  logic        i_br_less,
  input  logic        i_br_equal,
  input  logic [31:0] i_ex_target,
  input  logic        i_ex_pred_taken,
  input  logic [31:0] i_ex_pred_target,
  output logic        o_redirect,
  output logic [31:0] o_redirect_pc,
  output logic [31:0] o_br_cnt,
  output logic [31:0] o_mispred_cnt
);

  localparam int ENTRIES = 2 ** IDX_W;

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag [ENTRIES];
  logic [31:0]        r_tgt [ENTRIES];
  logic [1:0]         r_cnt [ENTRIES];
  logic [31:0]        r_br_cnt;
  logic [31:0]        r_mispred_cnt;

  logic [IDX_W-1:0] w_if_idx;
  logic [TAG_W-1:0] w_if_tag;
  logic             w_if_hit;
  logic [IDX_W-1:0] w_ex_idx;
  logic [TAG_W-1:0] w_ex_tag;
  logic             w_ex_hit;
  logic             w_taken;
  logic             w_act;
  logic [31:0]      w_next_pc;
  logic [1:0]       w_cnt_next;
  logic             w_unused_pred_taken;

  // The carried-down taken bit is implied by the carried-down target, so only the target is compared.
  assign w_unused_pred_taken = i_ex_pred_taken;

  assign w_if_idx      = i_if_pc[IDX_W+1:2];
  assign w_if_tag      = i_if_pc[31:IDX_W+2];
  assign w_if_hit      = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
  assign o_pred_taken  = w_if_hit & r_cnt[w_if_idx][1];
  assign o_pred_target = o_pred_taken ? r_tgt[w_if_idx] : (i_if_pc + 32'd4);

  always_comb begin
    w_taken = 1'b0;
    if (i_ex_is_jmp) begin
      w_taken = 1'b1;
    end else if (i_ex_is_br) begin
      case (i_ex_funct3)
        3'b000:  w_taken = i_br_equal;
        3'b001:  w_taken = ~i_br_equal;
        3'b100,
        3'b110:  w_taken = i_br_less;
        3'b101,
        3'b111:  w_taken = ~i_br_less;
        default: w_taken = 1'b0;
      endcase
    end
  end

  // act marks a live control-transfer in EX; only then may we redirect or train.
  assign w_act         = i_ex_valid & (i_ex_is_br | i_ex_is_jmp);
  assign w_next_pc     = w_taken ? i_ex_target : (i_ex_pc + 32'd4);
  assign o_redirect    = w_act & (w_next_pc != i_ex_pred_target);
  assign o_redirect_pc = w_next_pc;

  assign w_ex_idx = i_ex_pc[IDX_W+1:2];
  assign w_ex_tag = i_ex_pc[31:IDX_W+2];
  assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);

  always_comb begin
    w_cnt_next = r_cnt[w_ex_idx];
    if (w_taken && (r_cnt[w_ex_idx] != 2'b11)) begin
      w_cnt_next = r_cnt[w_ex_idx] + 2'b01;
    end else if (!w_taken && (r_cnt[w_ex_idx] != 2'b00)) begin
      w_cnt_next = r_cnt[w_ex_idx] - 2'b01;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid       <= '0;
      r_br_cnt      <= '0;
      r_mispred_cnt <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i] <= '0;
        r_tgt[i] <= '0;
        r_cnt[i] <= 2'b01;
      end
    end else if (w_act) begin
      r_br_cnt <= r_br_cnt + 32'd1;
      if (o_redirect) begin
        r_mispred_cnt <= r_mispred_cnt + 32'd1;
      end
      if (w_ex_hit) begin
        r_cnt[w_ex_idx] <= w_cnt_next;
        if (w_taken) begin
          r_tgt[w_ex_idx] <= i_ex_target;
        end
      end else if (w_taken) begin
        r_valid[w_ex_idx] <= 1'b1;
        r_tag[w_ex_idx]   <= w_ex_tag;
        r_tgt[w_ex_idx]   <= i_ex_target;
        r_cnt[w_ex_idx]   <= 2'b10;
      end
    end
  end

  assign o_br_cnt      = r_br_cnt;
  assign o_mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_bpu_2bit_dyn.sv
// Self-checking bench for bpu_2bit_dyn: scenario tasks with a redirect scoreboard queue.
module tb_bpu_2bit_dyn;

  logic        clk;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid, ex_is_br, ex_is_jmp;
  logic [31:0] ex_pc;
  logic [2:0]  ex_funct3;
  logic        br_less, br_equal;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] br_cnt, mispred_cnt;

  logic [32:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_br  = 0;
  logic [31:0] m_mis = 0;

  bpu_2bit_dyn dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_if_pc          (if_pc),
    .o_pred_taken     (pred_taken),
    .o_pred_target    (pred_target),
    .i_ex_valid       (ex_valid),
    .i_ex_is_br       (ex_is_br),
    .i_ex_is_jmp      (ex_is_jmp),
    .i_ex_pc          (ex_pc),
    .i_ex_funct3      (ex_funct3),
    .i_br_less        (br_less),
    .i_br_equal       (br_equal),
    .i_ex_target      (ex_target),
    .i_ex_pred_taken  (ex_pred_taken),
    .i_ex_pred_target (ex_pred_target),
    .o_redirect       (redirect),
    .o_redirect_pc    (redirect_pc),
    .o_br_cnt         (br_cnt),
    .o_mispred_cnt    (mispred_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  // drivers
  task automatic idle_ex();
    ex_valid = 0; ex_is_br = 0; ex_is_jmp = 0; ex_pc = 0; ex_funct3 = 0;
    br_less = 0; br_equal = 0; ex_target = 0; ex_pred_taken = 0; ex_pred_target = 0;
  endtask

  task automatic drive_ex(input logic v, input logic br, input logic jmp, input logic [31:0] pc,
                          input logic [2:0] f3, input logic less, input logic eq,
                          input logic [31:0] tgt, input logic [31:0] ptgt,
                          input logic exp_r, input logic [31:0] exp_pc);
    ex_valid = v; ex_is_br = br; ex_is_jmp = jmp; ex_pc = pc; ex_funct3 = f3;
    br_less = less; br_equal = eq; ex_target = tgt; ex_pred_target = ptgt;
    ex_pred_taken = (ptgt != pc + 32'd4);
    exp_q.push_back({exp_r, exp_pc});
    if (v && (br || jmp)) begin
      m_br = m_br + 1;
      if (exp_r) m_mis = m_mis + 1;
    end
  endtask

  // tests
  task automatic test_reset();
    rst_n = 0; idle_ex(); if_pc = 32'h100;
    @(negedge clk); #1;
    n_checks++;
    if (br_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_br_cnt: got %h want 0", br_cnt); end
    n_checks++;
    if (mispred_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_mis_cnt: got %h want 0", mispred_cnt); end
    n_checks++;
    if ({pred_taken, pred_target} !== {1'b0, 32'h104})
      begin n_fail++; $display("FAIL reset_lookup: got %0b/%h want 0/104", pred_taken, pred_target); end
    n_checks++;
    if (redirect !== 1'b0) begin n_fail++; $display("FAIL reset_redirect: got %0b want 0", redirect); end
    rst_n = 1;
  endtask

  task automatic test_beq_alloc();
    logic [32:0] e;
    @(negedge clk);
    if_pc = 32'h100;
    drive_ex(1, 1, 0, 32'h100, 3'b000, 0, 1, 32'h80, 32'h104, 1, 32'h80);
    #1;
    n_checks++;
    if ({pred_taken, pred_target} !== {1'b0, 32'h104})
      begin n_fail++; $display("FAIL beq_same_cycle_lookup: got %0b/%h want 0/104", pred_taken, pred_target); end
    e = exp_q.pop_front();
    n_checks++;
    if (redirect !== e[32] || (e[32] && redirect_pc !== e[31:0]))
      begin n_fail++; $display("FAIL beq_redirect: got %0b/%h want %0b/%h", redirect, redirect_pc, e[32], e[31:0]); end
    @(negedge clk); idle_ex(); #1;
    n_checks++;
    if ({pred_taken, pred_target} !== {1'b1, 32'h80})
      begin n_fail++; $display("FAIL beq_trained_lookup: got %0b/%h want 1/80", pred_taken, pred_target); end
  endtask

  task automatic test_bne_train();
    logic [32:0] e;
    logic        eqs  [6] = '{0, 0, 0, 0, 1, 1};
    logic [31:0] ptg  [6] = '{32'h204, 32'h240, 32'h240, 32'h240, 32'h240, 32'h240};
    logic        rexp [6] = '{1, 0, 0, 0, 1, 1};
    logic        ltk  [6] = '{0, 1, 1, 1, 1, 1};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if_pc = 32'h200;
      drive_ex(1, 1, 0, 32'h200, 3'b001, 0, eqs[i], 32'h240, ptg[i], rexp[i],
               eqs[i] ? 32'h204 : 32'h240);
      #1;
      n_checks++;
      if ({pred_taken, pred_target} !== {ltk[i], ltk[i] ? 32'h240 : 32'h204})
        begin n_fail++; $display("FAIL bne_lookup step %0d: got %0b/%h want %0b", i, pred_taken, pred_target, ltk[i]); end
      e = exp_q.pop_front();
      n_checks++;
      if (redirect !== e[32] || (e[32] && redirect_pc !== e[31:0]))
        begin n_fail++; $display("FAIL bne_redirect step %0d: got %0b/%h want %0b/%h", i, redirect, redirect_pc, e[32], e[31:0]); end
    end
    @(negedge clk); idle_ex(); #1;
    n_checks++;
    if ({pred_taken, pred_target} !== {1'b0, 32'h204})
      begin n_fail++; $display("FAIL bne_flip_lookup: got %0b/%h want 0/204", pred_taken, pred_target); end
  endtask

  task automatic test_decode();
    logic [32:0] e;
    logic [31:0] pcs  [5] = '{32'h604, 32'h708, 32'h708, 32'h80C, 32'h80C};
    logic [2:0]  f3s  [5] = '{3'b110, 3'b101, 3'b101, 3'b010, 3'b111};
    logic        lss  [5] = '{1, 1, 1, 1, 0};
    logic [31:0] tgs  [5] = '{32'h680, 32'h780, 32'h780, 32'h880, 32'h880};
    logic [31:0] ptg  [5] = '{32'h608, 32'h70C, 32'h780, 32'h810, 32'h810};
    logic        rexp [5] = '{1, 0, 1, 0, 1};
    logic [31:0] rpc  [5] = '{32'h680, 32'h0, 32'h70C, 32'h0, 32'h880};
    logic [31:0] lpc  [3] = '{32'h708, 32'h604, 32'h80C};
    logic [32:0] lexp [3] = '{{1'b0, 32'h70C}, {1'b1, 32'h680}, {1'b1, 32'h880}};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive_ex(1, 1, 0, pcs[i], f3s[i], lss[i], 1, tgs[i], ptg[i], rexp[i], rpc[i]);
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (redirect !== e[32] || (e[32] && redirect_pc !== e[31:0]))
        begin n_fail++; $display("FAIL decode_redirect step %0d: got %0b/%h want %0b/%h", i, redirect, redirect_pc, e[32], e[31:0]); end
    end
    @(negedge clk); idle_ex();
    for (int i = 0; i < 3; i++) begin
      if_pc = lpc[i]; #1;
      n_checks++;
      if ({pred_taken, pred_target} !== lexp[i])
        begin n_fail++; $display("FAIL decode_lookup pc %h: got %0b/%h want %h", lpc[i], pred_taken, pred_target, lexp[i]); end
    end
  endtask

  task automatic test_alias();
    logic [32:0] e;
    @(negedge clk);
    drive_ex(1, 1, 0, 32'h100, 3'b000, 0, 1, 32'h80, 32'h104, 1, 32'h80);
    #1; e = exp_q.pop_front();
    n_checks++;
    if (redirect !== e[32] || (e[32] && redirect_pc !== e[31:0]))
      begin n_fail++; $display("FAIL alias_first: got %0b/%h want %0b/%h", redirect, redirect_pc, e[32], e[31:0]); end
    @(negedge clk);
    if_pc = 32'h100;
    drive_ex(1, 1, 0, 32'h200, 3'b001, 0, 0, 32'h2F0, 32'h204, 1, 32'h2F0);
    #1;
    n_checks++;
    if ({pred_taken, pred_target} !== {1'b1, 32'h80})
      begin n_fail++; $display("FAIL alias_before_evict: got %0b/%h want 1/80", pred_taken, pred_target); end
    e = exp_q.pop_front();
    n_checks++;
    if (redirect !== e[32] || (e[32] && redirect_pc !== e[31:0]))
      begin n_fail++; $display("FAIL alias_second: got %0b/%h want %0b/%h", redirect, redirect_pc, e[32], e[31:0]); end
    @(negedge clk); idle_ex(); #1;
    n_checks++;
    if ({pred_taken, pred_target} !== {1'b0, 32'h104})
      begin n_fail++; $display("FAIL alias_evicted: got %0b/%h want 0/104", pred_taken, pred_target); end
    if_pc = 32'h200; #1;
    n_checks++;
    if ({pred_taken, pred_target} !== {1'b1, 32'h2F0})
      begin n_fail++; $display("FAIL alias_new: got %0b/%h want 1/2f0", pred_taken, pred_target); end
  endtask

  task automatic test_jalr();
    logic [32:0] e;
    logic        brs  [3] = '{0, 0, 1};
    logic [31:0] tgs  [3] = '{32'h400, 32'h500, 32'h500};
    logic [31:0] ptg  [3] = '{32'h304, 32'h400, 32'h500};
    logic        rexp [3] = '{1, 1, 0};
    logic [32:0] lexp [3] = '{{1'b0, 32'h304}, {1'b1, 32'h400}, {1'b1, 32'h500}};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if_pc = 32'h300;
      drive_ex(1, brs[i], 1, 32'h300, 3'b010, 0, 0, tgs[i], ptg[i], rexp[i], tgs[i]);
      #1;
      n_checks++;
      if ({pred_taken, pred_target} !== lexp[i])
        begin n_fail++; $display("FAIL jalr_lookup step %0d: got %0b/%h want %h", i, pred_taken, pred_target, lexp[i]); end
      e = exp_q.pop_front();
      n_checks++;
      if (redirect !== e[32] || (e[32] && redirect_pc !== e[31:0]))
        begin n_fail++; $display("FAIL jalr_redirect step %0d: got %0b/%h want %0b/%h", i, redirect, redirect_pc, e[32], e[31:0]); end
    end
  endtask

  task automatic test_stall();
    logic [32:0] e;
    logic [31:0] pc;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pc = {20'h0, 4'h9, 2'($urandom_range(0, 3)), 4'h0, 2'b00};
      drive_ex(0, 1, (i == 3), pc, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 32'hA00, pc + 32'h40, 0, 32'h0);
      #1; e = exp_q.pop_front();
      n_checks++;
      if (redirect !== e[32])
        begin n_fail++; $display("FAIL stall_redirect step %0d: got %0b want %0b", i, redirect, e[32]); end
    end
    @(negedge clk); idle_ex(); if_pc = 32'h900; #1;
    n_checks++;
    if ({pred_taken, pred_target} !== {1'b0, 32'h904})
      begin n_fail++; $display("FAIL stall_no_alloc: got %0b/%h want 0/904", pred_taken, pred_target); end
    n_checks++;
    if (br_cnt !== m_br) begin n_fail++; $display("FAIL br_cnt: got %0d want %0d", br_cnt, m_br); end
    n_checks++;
    if (mispred_cnt !== m_mis) begin n_fail++; $display("FAIL mispred_cnt: got %0d want %0d", mispred_cnt, m_mis); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); idle_ex(); if_pc = 32'h300;
    #2; rst_n = 0; #1;
    n_checks++;
    if (br_cnt !== 32'd0) begin n_fail++; $display("FAIL midreset_br_cnt: got %0d want 0", br_cnt); end
    n_checks++;
    if (mispred_cnt !== 32'd0) begin n_fail++; $display("FAIL midreset_mis_cnt: got %0d want 0", mispred_cnt); end
    n_checks++;
    if ({pred_taken, pred_target} !== {1'b0, 32'h304})
      begin n_fail++; $display("FAIL midreset_lookup: got %0b/%h want 0/304", pred_taken, pred_target); end
    m_br = 0; m_mis = 0;
    @(negedge clk); rst_n = 1;
  endtask

  initial begin
    test_reset();
    test_beq_alloc();
    test_bne_train();
    test_decode();
    test_alias();
    test_jalr();
    test_stall();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d left", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
